// File: rtl/main_memory.sv
// main_memory: fixed-latency 256-bit line store for the data cache controller.
// One request in flight; registered ack and read data arrive LATENCY edges after acceptance.
module main_memory #(
  parameter int LATENCY = 10,
  parameter int DEPTH = 512
) (
  input  logic         clk_i,
  input  logic         rst_i,
  input  logic         enable_i,
  input  logic         write_i,
  input  logic [31:0]  addr_i,
  input  logic [255:0] data_i,
  output logic         ack_o,
  output logic [255:0] data_o
);
  localparam int IW = $clog2(DEPTH);
  localparam logic [1:0] IDLE = 2'd0, BUSY = 2'd1, ACK = 2'd2;
  logic [1:0] state;
  logic [7:0] count;
  logic writeReg;
  logic [IW-1:0] indexReg;
  logic [255:0] dataReg;
  logic [255:0] mem [DEPTH];
  logic unusedAddrBits;
  assign unusedAddrBits = ^{addr_i[31:5+IW], addr_i[4:0]};
  // ACK state precedes the ack pulse by one edge, so the FSM is already IDLE while ack_o is high
  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) begin
      state <= IDLE;
      count <= '0;
      writeReg <= 1'b0;
      indexReg <= '0;
      dataReg <= '0;
      ack_o <= 1'b0;
      data_o <= '0;
    end else begin
      ack_o <= state == ACK;
      case (state)
        IDLE: if (enable_i) begin
          state <= BUSY;
          count <= 8'(LATENCY - 1);
          writeReg <= write_i;
          indexReg <= addr_i[5+IW-1:5];
          dataReg <= data_i;
        end
        BUSY: begin
          count <= count - 8'd1;
          if (count == 8'd1) state <= ACK;
        end
        default: begin
          state <= IDLE;
          if (state == ACK && !writeReg) data_o <= mem[indexReg];
        end
      endcase
    end
  end
  always_ff @(posedge clk_i) if (state == ACK && writeReg) mem[indexReg] <= dataReg;
endmodule

// File: tb/tb_main_memory.sv
// tb_main_memory: table-driven requests with an in-order scoreboard of expected acks,
// plus hand sequences for throughput and reset-during-busy.
module tb_main_memory;
  localparam int LATENCY = 10;
  localparam int DEPTH = 512;
  typedef struct {
    bit wr;
    bit hold;
    bit disturb;
    logic [31:0] addr;
    logic [255:0] data;
    logic [255:0] exp;
  } vec_t;
  typedef struct {
    bit wr;
    logic [255:0] exp;
  } sb_t;
  logic clk_i = 1'b0;
  logic rst_i = 1'b0;
  logic enable_i = 1'b0;
  logic write_i = 1'b0;
  logic [31:0] addr_i = '0;
  logic [255:0] data_i = '0;
  logic ack_o;
  logic [255:0] data_o;
  int checks = 0;
  int failures = 0;
  logic [255:0] lastData = '0;
  sb_t sb[$];
  vec_t vecs[12];
  main_memory #(.LATENCY(LATENCY), .DEPTH(DEPTH)) dut (
    .clk_i(clk_i),
    .rst_i(rst_i),
    .enable_i(enable_i),
    .write_i(write_i),
    .addr_i(addr_i),
    .data_i(data_i),
    .ack_o(ack_o),
    .data_o(data_o)
  );
  always #5 clk_i = ~clk_i;
  task automatic check(input string name, input logic [255:0] act, input logic [255:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%h required=%h", name, act, exp);
    end
  endtask
  initial forever begin
    sb_t e;
    @(posedge clk_i);
    #1;
    if (ack_o) begin
      if (sb.size() == 0) begin
        checks++;
        failures++;
        $display("FAIL unexpectedAck actual=1 required=0");
      end else begin
        e = sb.pop_front();
        if (e.wr) check("writeHoldsData", data_o, lastData);
        else begin
          check("readData", data_o, e.exp);
          lastData = e.exp;
        end
      end
    end
  end
  task automatic doReq(input vec_t v, input bit releaseRst);
    int lat;
    int acks;
    @(negedge clk_i);
    if (releaseRst) rst_i = 1'b1;
    enable_i = 1'b1;
    write_i = v.wr;
    addr_i = v.addr;
    data_i = v.data;
    sb.push_back('{wr: v.wr, exp: v.exp});
    @(posedge clk_i);
    #1;
    if (!v.hold) enable_i = 1'b0;
    lat = 0;
    acks = 0;
    for (int j = 1; j <= LATENCY + 4; j++) begin
      if (v.disturb && j == 3) begin
        enable_i = 1'b1;
        write_i = 1'b1;
        addr_i = 32'h80;
        data_i = '0;
      end
      @(posedge clk_i);
      #1;
      if (ack_o) begin
        acks++;
        if (lat == 0) lat = j;
        enable_i = 1'b0;
      end
    end
    enable_i = 1'b0;
    check("ackLatency", 256'(lat), 256'(LATENCY));
    check("ackCount", 256'(acks), 256'd1);
  endtask
  initial begin
    int ackEdges[$];
    vec_t rd;
    vecs[0]  = '{wr: 1, hold: 0, disturb: 0, addr: 32'h20,   data: {32{8'hA5}}, exp: '0};
    vecs[1]  = '{wr: 0, hold: 0, disturb: 0, addr: 32'h20,   data: '0, exp: {32{8'hA5}}};
    vecs[2]  = '{wr: 1, hold: 0, disturb: 0, addr: 32'h4000, data: {8{32'hC0DE0001}}, exp: '0};
    vecs[3]  = '{wr: 0, hold: 0, disturb: 0, addr: 32'h0,    data: '0, exp: {8{32'hC0DE0001}}};
    vecs[4]  = '{wr: 0, hold: 1, disturb: 0, addr: 32'h1F,   data: '0, exp: {8{32'hC0DE0001}}};
    vecs[5]  = '{wr: 1, hold: 0, disturb: 0, addr: 32'h80,   data: {32{8'h44}}, exp: '0};
    vecs[6]  = '{wr: 1, hold: 0, disturb: 1, addr: 32'h40,   data: {32{8'h22}}, exp: '0};
    vecs[7]  = '{wr: 0, hold: 0, disturb: 0, addr: 32'h80,   data: '0, exp: {32{8'h44}}};
    vecs[8]  = '{wr: 0, hold: 0, disturb: 0, addr: 32'h40,   data: '0, exp: {32{8'h22}}};
    vecs[9]  = '{wr: 1, hold: 0, disturb: 0, addr: 32'h60,   data: {32{8'h11}}, exp: '0};
    vecs[10] = '{wr: 0, hold: 0, disturb: 0, addr: 32'h60,   data: '0, exp: {32{8'h11}}};
    vecs[11] = '{wr: 0, hold: 0, disturb: 0, addr: 32'h20,   data: '0, exp: {32{8'hA5}}};
    #12;
    check("resetAck", 256'(ack_o), 256'd0);
    check("resetData", data_o, '0);
    @(negedge clk_i);
    rst_i = 1'b1;
    for (int i = 0; i < 12; i++) doReq(vecs[i], 1'b0);
    for (int i = 0; i < 3; i++) sb.push_back('{wr: 0, exp: {32{8'hA5}}});
    @(negedge clk_i);
    enable_i = 1'b1;
    write_i = 1'b0;
    addr_i = 32'h20;
    for (int c = 1; c <= 40; c++) begin
      @(posedge clk_i);
      #1;
      if (ack_o) begin
        ackEdges.push_back(c);
        if (ackEdges.size() >= 3) enable_i = 1'b0;
      end
    end
    enable_i = 1'b0;
    check("holdAckCount", 256'(ackEdges.size()), 256'd3);
    if (ackEdges.size() == 3) begin
      check("holdAck0", 256'(ackEdges[0]), 256'd11);
      check("holdAck1", 256'(ackEdges[1]), 256'd22);
      check("holdAck2", 256'(ackEdges[2]), 256'd33);
    end
    @(negedge clk_i);
    enable_i = 1'b1;
    write_i = 1'b1;
    addr_i = 32'h60;
    data_i = {32{8'hFF}};
    @(posedge clk_i);
    #1;
    enable_i = 1'b0;
    repeat (5) @(posedge clk_i);
    #2;
    rst_i = 1'b0;
    lastData = '0;
    #1;
    check("midResetAck", 256'(ack_o), 256'd0);
    check("midResetData", data_o, '0);
    repeat (2) begin
      @(posedge clk_i);
      #1;
      check("heldResetAck", 256'(ack_o), 256'd0);
      check("heldResetData", data_o, '0);
    end
    rd = '{wr: 0, hold: 0, disturb: 0, addr: 32'h60, data: '0, exp: {32{8'h11}}};
    doReq(rd, 1'b1);
    check("scoreboardDrained", 256'(sb.size()), 256'd0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
  initial begin
    #100000;
    $display("FAIL watchdog actual=timeout required=finish");
    $fatal(1, "watchdog expired");
  end
endmodule
